// File: rtl/sort_job_ctrl.sv
// Job sequencer for the bubble-sort engine: loads DEPTH words, hands memory to the engine, drains sorted words.
// Optional SORT_WAIT watchdog enabled by defining SORT_JOB_TIMEOUT_EN.
module sort_job_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              sort_start,
  input  logic              sort_done,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              job_done,
  output logic              timeout_err
);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_depth_range
    $error("sort_job_ctrl: DEPTH must lie in 2..2**ADDR_W");
  end
  if (TIMEOUT < 1 || TIMEOUT > 4095) begin : g_timeout_range
    $error("sort_job_ctrl: TIMEOUT must fit the 12-bit watchdog");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SORT_START,
    SORT_WAIT,
    FETCH,
    HOLD,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_last, rd_last;
  logic              to_expired;

  assign wr_last   = (wr_ptr == LAST);
  assign rd_last   = (rd_ptr == LAST);
  assign busy      = (state != IDLE);
  assign mem_wdata = in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    sort_start = 1'b0;
    mem_sel    = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    job_done   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        mem_addr = wr_ptr;
        mem_we   = in_valid;
        if (in_valid && wr_last) state_nxt = SORT_START;
      end
      SORT_START: begin
        mem_sel    = 1'b1;
        sort_start = 1'b1;
        state_nxt  = SORT_WAIT;
      end
      SORT_WAIT: begin
        mem_sel = 1'b1;
        if (sort_done)       state_nxt = FETCH;
        else if (to_expired) state_nxt = IDLE;
      end
      FETCH: begin
        mem_addr  = rd_ptr;
        mem_re    = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = rd_last ? DONE : FETCH;
      end
      DONE: begin
        job_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pointers stop at DEPTH-1; the state machine leaves LOAD/HOLD instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
          end
        end
        LOAD:    if (in_valid && !wr_last) wr_ptr <= wr_ptr + 1'b1;
        HOLD:    if (out_ready && !rd_last) rd_ptr <= rd_ptr + 1'b1;
        default: ;
      endcase
    end
  end

  // ---- fetch -> hold boundary: registered drain word ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 out_data <= '0;
    else if (state == FETCH) out_data <= mem_rdata;
  end

`ifdef SORT_JOB_TIMEOUT_EN
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  logic [11:0] to_cnt;
  logic        to_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      to_cnt <= '0;
    else if (state == SORT_START) to_cnt <= '0;
    else if (state == SORT_WAIT)  to_cnt <= to_cnt + 1'b1;
  end

  // fires on the TIMEOUT-th SORT_WAIT cycle, so IDLE follows exactly TIMEOUT wait cycles
  assign to_expired = (state == SORT_WAIT) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          to_flag <= 1'b0;
    else if (state == IDLE && start)  to_flag <= 1'b0;
    else if (to_expired && !sort_done) to_flag <= 1'b1;
  end

  assign timeout_err = to_flag;
`else
  assign to_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_job_ctrl.sv
// Randomized bench for sort_job_ctrl: behavioural memory + sort engine model, scoreboard of sorted output.
module tb_sort_job_ctrl;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 50;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, out_valid, sort_start, sort_done, mem_sel;
  logic              mem_we, mem_re, busy, job_done, timeout_err;
  logic [DATA_W-1:0] out_data, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_t mem;
  int   sort_lat = 100;
  bit   eng_en   = 1'b1;
  int   eng_cnt  = -1;
  logic eng_done = 1'b0;
  logic inj_done = 1'b0;

  always #5 clk = ~clk;

  sort_job_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sort_start(sort_start), .sort_done(sort_done), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .job_done(job_done), .timeout_err(timeout_err)
  );

  assign sort_done = eng_done | inj_done;
  assign mem_rdata = mem[mem_addr];

  function automatic mem_t sort_mem(input mem_t m);
    mem_t r = m;
    logic [DATA_W-1:0] t;
    for (int a = 0; a < DEPTH - 1; a++)
      for (int b = 0; b < DEPTH - 1 - a; b++)
        if (r[b] > r[b+1]) begin
          t = r[b]; r[b] = r[b+1]; r[b+1] = t;
        end
    return r;
  endfunction

  // single-port memory plus a sort engine that sorts in place after sort_lat cycles
  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (!mem_sel && mem_we) mem[mem_addr] <= mem_wdata;
    if (sort_start && eng_en) eng_cnt <= sort_lat;
    else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
    else if (eng_cnt == 0) begin
      eng_cnt  <= -1;
      eng_done <= 1'b1;
      mem      <= sort_mem(mem);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input string tag, input int gap_pct, input int stall,
                         input bit inject, input bit desc);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] held = '0;
    int nwr = 0, nss = 0, njd = 0, i = 0;
    int last_wr = -1, ss_cyc = -1, sd_cyc = -1, ov_cyc = -1, last_out = -1, jd_cyc = -1;
    int bad_addr = 0, bad_rdy = 0, bad_stall = 0, stall_left = stall;
    bit inj_s = 1'b0, inj_d = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (jd_cyc < 0 && i < 3000) begin
      in_valid  = (int'($urandom_range(99)) >= gap_pct);
      in_data   = desc ? DATA_W'(DEPTH - 1 - nwr) : DATA_W'($urandom);
      out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(3) != 0);
      if (inject && !inj_d && nwr == 3) begin
        inj_done = 1'b1; inj_d = 1'b1;
      end
      if (inject && !inj_s && ss_cyc >= 0 && sd_cyc < 0 && i > ss_cyc + 5) begin
        start = 1'b1; inj_s = 1'b1;
      end
      #1;
      if (in_valid && in_ready) begin
        if (mem_addr != nwr[ADDR_W-1:0] || !mem_we) bad_addr++;
        exp_q.push_back(in_data);
        nwr++;
        last_wr = i;
      end
      if (ss_cyc >= 0 && in_ready) bad_rdy++;
      if (mem_we && !in_ready) bad_rdy++;
      if (sort_start) begin
        nss++;
        if (ss_cyc < 0) ss_cyc = i;
      end
      if (eng_done && sd_cyc < 0) begin
        sd_cyc = i;
        check({tag, ".msel_at_done"}, 32'(mem_sel), 32'd1);
      end
      if (sd_cyc >= 0 && i == sd_cyc + 1)
        check({tag, ".fetch_strobes"}, {30'd0, mem_sel, mem_re}, 32'b01);
      if (out_valid && ov_cyc < 0) begin
        ov_cyc = i;
        held   = out_data;
      end
      if (ov_cyc >= 0 && stall_left > 0) begin
        if (!out_valid || out_data != held) bad_stall++;
        stall_left--;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_out = i;
      end
      if (job_done) begin
        njd++;
        jd_cyc = i;
      end
      @(posedge clk); #1;
      inj_done = 1'b0;
      start    = 1'b0;
      i++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check({tag, ".finished"}, 32'(jd_cyc >= 0), 32'd1);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
    check({tag, ".writes"}, 32'(nwr), 32'(DEPTH));
    check({tag, ".write_addr_order"}, 32'(bad_addr), 32'd0);
    check({tag, ".ready_outside_load"}, 32'(bad_rdy), 32'd0);
    check({tag, ".sort_start_pulses"}, 32'(nss), 32'd1);
    check({tag, ".sort_start_lat"}, 32'(ss_cyc - last_wr), 32'd1);
    check({tag, ".first_valid_lat"}, 32'(ov_cyc - sd_cyc), 32'd2);
    check({tag, ".job_done_lat"}, 32'(jd_cyc - last_out), 32'd1);
    check({tag, ".job_done_count"}, 32'(njd), 32'd1);
    check({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
    if (stall > 0) check({tag, ".hold_stall"}, 32'(bad_stall), 32'd0);
    exp_q.sort();
    check({tag, ".out_count"}, 32'(got_q.size()), 32'(DEPTH));
    for (int k = 0; k < DEPTH && k < got_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s.out[%0d]", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
  endtask

  task automatic reset_mid_load();
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("rst_mid.outputs",
          {23'd0, busy, in_ready, out_valid, sort_start, mem_sel, mem_we, mem_re, job_done, timeout_err},
          32'd0);
    check("rst_mid.out_data", 32'(out_data), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef SORT_JOB_TIMEOUT_EN
  task automatic timeout_job();
    int i = 0, nwait = 0, njd = 0;
    bit seen_ss = 1'b0;
    eng_en = 1'b0;
    start  = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    while (busy && i < 500) begin
      in_data = DATA_W'($urandom);
      #1;
      if (sort_start) seen_ss = 1'b1;
      else if (seen_ss && mem_sel) nwait++;
      if (job_done) njd++;
      @(posedge clk); #1;
      i++;
    end
    in_valid = 1'b0;
    #1;
    check("to.reached_idle", 32'(busy), 32'd0);
    check("to.wait_cycles", 32'(nwait), 32'(TIMEOUT));
    check("to.err_set", 32'(timeout_err), 32'd1);
    check("to.mem_sel", 32'(mem_sel), 32'd0);
    check("to.no_job_done", 32'(njd), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check("to.err_cleared", 32'(timeout_err), 32'd0);
    rst = 1'b1;
    #2;
    rst    = 1'b0;
    eng_en = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #3;
    check("reset.outputs",
          {23'd0, busy, in_ready, out_valid, sort_start, mem_sel, mem_we, mem_re, job_done, timeout_err},
          32'd0);
    check("reset.out_data", 32'(out_data), 32'd0);
    #9;
    rst = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("idle.in_ready", {30'd0, in_ready, mem_we}, 32'd0);
    check("idle.busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    sort_lat = 100;
    run_job("job_desc", 0, 0, 1'b0, 1'b1);
    sort_lat = int'($urandom_range(60, 5));
    run_job("job_gaps_stall", 40, 10, 1'b1, 1'b0);
    reset_mid_load();
    sort_lat = int'($urandom_range(60, 5));
    run_job("job_after_rst", 20, 0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      sort_lat = int'($urandom_range(40, 1));
      run_job($sformatf("job_rand%0d", r), int'($urandom_range(60)), int'($urandom_range(12)),
              1'b1, 1'b0);
    end
`ifdef SORT_JOB_TIMEOUT_EN
    timeout_job();
    run_job("job_after_to", 10, 0, 1'b0, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
